// File: rtl/robust_rx.sv
// Receive buffer for a transmitter with no backpressure: a small FIFO that
// drops beats when full and records the losses in a sticky flag and a saturating counter.
module robust_rx #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     valid,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;
    logic             drop;

    assign pop  = out_valid && out_ready;
    assign push = valid && ((count_q != FULL) || pop);
    assign drop = valid && !push;

    assign count     = count_q;
    assign out_valid = (count_q != '0);
    // Storage is never reset, so the head is masked while the buffer is empty.
    assign data_out  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // DEPTH is a power of two, so the natural AW-bit wrap is the modulo.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A drop in the same cycle as a clear takes priority and restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= 8'd1;
            end else if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_robust_rx.sv
// Bench for robust_rx: directed scenarios plus random traffic, checked against
// a queue-based model of the buffer and its drop accounting.
module tb_robust_rx;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH-1:0]       data_in;
    logic                   valid;
    logic [WIDTH-1:0]       data_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   ovf_clr;
    logic [7:0]             drop_cnt;

    robust_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid     (valid),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q [$];
    bit               model_ovf;
    int               model_drops;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [WIDTH-1:0] head;
        head = (model_q.size() != 0) ? model_q[0] : '0;
        check({tag, ".count"},     64'(count),     64'(model_q.size()));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
        check({tag, ".data_out"},  64'(data_out),  64'(head));
        check({tag, ".overflow"},  64'(overflow),  64'(model_ovf));
        check({tag, ".drop_cnt"},  64'(drop_cnt),  64'(model_drops));
    endtask

    task automatic model_reset();
        model_q.delete();
        model_ovf   = 0;
        model_drops = 0;
    endtask

    // Called at a negedge: drive one cycle of inputs, advance the model, check at the next negedge.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, input bit r, input bit c, input string tag);
        bit do_pop;
        bit do_push;
        valid     = v;
        data_in   = d;
        out_ready = r;
        ovf_clr   = c;
        do_pop  = (model_q.size() != 0) && r;
        do_push = v && ((model_q.size() < DEPTH) || do_pop);
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        if (v && !do_push) begin
            model_ovf   = 1;
            model_drops = c ? 1 : ((model_drops < 255) ? model_drops + 1 : 255);
        end else if (c) begin
            model_ovf   = 0;
            model_drops = 0;
        end
        @(posedge clk);
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        model_reset();
        #1;
        check("reset.count",     64'(count),     64'd0);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.data_out",  64'(data_out),  64'd0);
        check("reset.overflow",  64'(overflow),  64'd0);
        check("reset.drop_cnt",  64'(drop_cnt),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single beat, held until the consumer is ready
        cycle(1, 32'hDEADBEEF, 0, 0, "single_push");
        check("single.data_out", 64'(data_out), 64'hDEADBEEF);
        check("single.count",    64'(count),    64'd1);
        cycle(0, '0, 1, 0, "single_pop");
        check("single.empty",    64'(data_out), 64'd0);

        // Fill, overflow by one, drain in order
        for (int i = 1; i <= 4; i++) cycle(1, WIDTH'(i), 0, 0, "fill");
        check("fill.count", 64'(count), 64'd4);
        cycle(1, 32'd5, 0, 0, "fill_drop");
        check("fill.overflow", 64'(overflow), 64'd1);
        check("fill.drop_cnt", 64'(drop_cnt), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("drain.order", 64'(data_out), 64'(i));
            cycle(0, '0, 1, 0, "drain");
        end
        cycle(0, '0, 0, 1, "clear");

        // Streaming while full across pointer wrap
        for (int i = 0; i < 4; i++) cycle(1, WIDTH'(10 + i), 0, 0, "stream_fill");
        for (int i = 0; i < 10; i++) begin
            check("stream.head", 64'(data_out), 64'(10 + i));
            cycle(1, WIDTH'(14 + i), 1, 0, "stream");
        end
        check("stream.count",    64'(count),    64'd4);
        check("stream.drop_cnt", 64'(drop_cnt), 64'd0);

        // Drop counter saturation and clear priority
        for (int i = 0; i < 300; i++) cycle(1, WIDTH'($urandom), 0, 0, "saturate");
        check("sat.drop_cnt", 64'(drop_cnt), 64'd255);
        cycle(1, 32'h1234, 0, 1, "clr_with_drop");
        check("clr_drop.overflow", 64'(overflow), 64'd1);
        check("clr_drop.drop_cnt", 64'(drop_cnt), 64'd1);
        cycle(0, '0, 0, 1, "clr_alone");
        check("clr.overflow", 64'(overflow), 64'd0);
        check("clr.drop_cnt", 64'(drop_cnt), 64'd0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 1, 0, "sat_drain");

        // Asynchronous reset mid-traffic
        for (int i = 0; i < 3; i++) cycle(1, WIDTH'(32'h100 + i), 0, 0, "pre_reset");
        check("pre_reset.count", 64'(count), 64'd3);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.count",     64'(count),     64'd0);
        check("async_rst.out_valid", 64'(out_valid), 64'd0);
        check("async_rst.data_out",  64'(data_out),  64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 32'hA5, 0, 0, "post_reset");
        check("post_reset.data_out", 64'(data_out), 64'hA5);
        check("post_reset.count",    64'(count),    64'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 60), WIDTH'($urandom), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 3), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/robust_rx.md
ROBUST_RX -- requirements
Module: robust_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data beat width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 4, buffer entries (power of 2, >=2).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port data_in  input  WIDTH  incoming beat from the upstream transmitter.
REQ-006 The block SHALL have port valid  input  1  data_in qualifier; upstream has no backpressure.
REQ-007 The block SHALL have port data_out  output  WIDTH  head-of-buffer beat.
REQ-008 The block SHALL have port out_valid  output  1  data_out holds a buffered beat.
REQ-009 The block SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-010 The block SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-011 The block SHALL have port overflow  output  1  sticky flag: a beat was dropped.
REQ-012 The block SHALL have port ovf_clr  input  1  synchronous clear of overflow and drop_cnt.
REQ-013 The block SHALL have port drop_cnt  output  8  saturating count of dropped beats.

Function
REQ-014 Push SHALL occur when valid=1 and (count<DEPTH or pop in the same cycle); data_in is written at wr_ptr and wr_ptr advances.
REQ-015 Pop SHALL occur when out_valid=1 and out_ready=1; rd_ptr advances.
REQ-016 wr_ptr and rd_ptr SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-017 count SHALL be +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-018 out_valid SHALL equal (count!=0), derived from registered count.
REQ-019 data_out SHALL equal the entry at rd_ptr when count!=0, else all zeros.
REQ-020 Latency: a beat pushed into an empty buffer at edge N SHALL appear on data_out/out_valid after edge N (visible in cycle N+1); no combinational bypass from data_in to data_out.
REQ-021 Empty with valid=1 and out_ready=1: push only, no pop; count 0->1.
REQ-022 Full (count==DEPTH) with valid=1 and pop: push and pop both accepted, count stays DEPTH, no drop.
REQ-023 Full with valid=1 and no pop: beat SHALL be dropped, buffer unchanged, overflow set to 1, drop_cnt +1 saturating at 255.
REQ-024 ovf_clr=1 SHALL set overflow=0 and drop_cnt=0 next edge; a drop in the same cycle wins: overflow=1, drop_cnt=1.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 Beats SHALL leave in arrival order; no beat duplicated or reordered.

Reset
REQ-027 rst_n=0 SHALL immediately (asynchronously) force count=0, out_valid=0, data_out=0, overflow=0, drop_cnt=0, wr_ptr=rd_ptr=0.
REQ-028 Buffer storage SHALL need no reset; contents are unobservable while count=0.
REQ-029 Reset asserted mid-traffic SHALL discard all buffered beats; first valid beat after release is stored at entry 0 and appears as the next data_out.
REQ-030 Reset deassertion SHALL be synchronised externally; the block takes no action on release other than resuming normal operation.

Verification
REQ-031 Single beat: empty, valid=1 data_in=0xDEADBEEF one cycle, out_ready=0 -> next cycle out_valid=1, data_out=0xDEADBEEF, count=1; then out_ready=1 -> count=0, data_out=0.
REQ-032 Fill/drain: push 1,2,3,4 back-to-back with out_ready=0 -> count=4; a 5th beat 5 -> dropped, overflow=1, drop_cnt=1; drain -> 1,2,3,4 in order.
REQ-033 Full streaming: count=4, valid=1 and out_ready=1 for 10 cycles with incrementing data -> count stays 4, no drops, outputs strictly in order across pointer wrap.
REQ-034 Saturation/clear: 300 drops while full -> drop_cnt=255; ovf_clr with simultaneous drop -> overflow=1, drop_cnt=1; ovf_clr alone -> both 0.
REQ-035 Reset mid-operation: count=3, assert rst_n=0 between edges -> out_valid, count, data_out go 0 without a clock edge; after release push 0xA5 -> data_out=0xA5, count=1.
